// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared definitions for the RSA encode/decode datapath.
//                Handshake pulse rules shared by the multiplier, reducer and
//                exponentiation controller: a start request acts only on the
//                rising edge of its level input, and a Done output is a
//                single-cycle pulse that qualifies the result it accompanies.
//  Revision    : 1.0  initial release
// ============================================================================
package rsa_pkg;

    // Operand / result width of the datapath
    localparam int RSA_W = 8;

    // Reducer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rsa_cond_sub.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_cond_sub
//  Description : Combinational (W+1)-bit unsigned compare-and-subtract,
//                r = (t >= n) ? t - n : t.  Callers keep the running remainder
//                below n, so the result always fits in W bits and only the
//                low W bits are returned.
//  Revision    : 1.0  initial release
// ============================================================================
module rsa_cond_sub
    import rsa_pkg::*;
#(
    parameter int W = RSA_W
) (
    input  logic [W:0]   t,
    input  logic [W:0]   n,
    output logic [W-1:0] r
);

    // Restoring step: subtract only when the trial value reaches the modulus
    always_comb begin
        r = t[W-1:0];
        if (t >= n) begin
            r = W'(t - n);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_reduce_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : mod_reduce_8bit
//  Description : Sequential modular reducer R = P mod N using restoring
//                shift-subtract, one dividend bit per clock. Started by the
//                rising edge of Enable (the multiplier's H1 flag). N == 0 is
//                flagged on Err with R = P.
//  Revision    : 1.0  initial release
// ============================================================================
module mod_reduce_8bit
    import rsa_pkg::*;
#(
    parameter int W     = RSA_W,
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Enable,
    input  logic [W-1:0] P,
    input  logic [W-1:0] N,
    output logic [W-1:0] R,
    output logic         Done,
    output logic         Busy,
    output logic         Err
);

    state_t             state;
    logic               enable_q;
    logic               start;
    logic [W-1:0]       p_q;
    logic [W-1:0]       n_q;
    logic [W-1:0]       rem;
    logic [CNT_W-1:0]   cnt;
    logic [W:0]         t;
    logic [W-1:0]       rem_next;

    // Enable is a level; only its rising edge requests a reduction
    assign start = Enable & ~enable_q;

    // Bring the next dividend bit (MSB first) into the partial remainder
    assign t = {rem, p_q[cnt]};

    rsa_cond_sub #(
        .W (W)
    ) u_cond_sub (
        .t (t),
        .n ({1'b0, n_q}),
        .r (rem_next)
    );

    // Enable history, tracked every cycle regardless of state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
        end else begin
            enable_q <= Enable;
        end
    end

    // Control FSM with operand capture, iteration counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            p_q   <= '0;
            n_q   <= '0;
            rem   <= '0;
            cnt   <= '0;
            R     <= '0;
            Done  <= 1'b0;
            Busy  <= 1'b0;
            Err   <= 1'b0;
        end else begin
            // Done is a single-cycle pulse, raised only from DONE
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        p_q <= P;
                        n_q <= N;
                        rem <= '0;
                        cnt <= CNT_W'(W - 1);
                        if (N == '0) begin
                            // Nothing to divide by: report straight away
                            state <= DONE;
                        end else begin
                            state <= CALC;
                            Busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    if (cnt == '0) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // A zero modulus passes the dividend through unchanged
                    R     <= (n_q == '0) ? p_q : rem;
                    Err   <= (n_q == '0);
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_reduce_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_reduce_8bit
//  Description : Self-checking bench for mod_reduce_8bit. A cycle-level
//                reference model (P % N with fixed latency) is compared against
//                the DUT every cycle; directed operations carry hand-computed
//                results and latencies.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mod_reduce_8bit;

    localparam int W = 8;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         Enable = 1'b0;
    logic [W-1:0] P      = '0;
    logic [W-1:0] N      = '0;
    logic [W-1:0] R;
    logic         Done;
    logic         Busy;
    logic         Err;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    mod_reduce_8bit #(
        .W     (W),
        .CNT_W (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Enable (Enable),
        .P      (P),
        .N      (N),
        .R      (R),
        .Done   (Done),
        .Busy   (Busy),
        .Err    (Err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a reduction accepted on an Enable rising edge while
    // not already servicing one; result P%N (or P with Err for N==0) shows up
    // a fixed number of cycles after the capture edge.
    // ------------------------------------------------------------------
    bit           m_active  = 0;
    int           m_elapsed = 0;
    int           m_lat     = 0;
    bit           m_en_prev = 0;
    bit           pend_err  = 0;
    logic [W-1:0] pend_r    = '0;
    logic [W-1:0] m_R       = '0;
    bit           m_Err     = 0;
    bit           exp_done  = 0;
    bit           exp_busy  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  = 0;
            m_elapsed = 0;
            m_en_prev = 0;
            m_R       = '0;
            m_Err     = 0;
            exp_done  = 0;
            exp_busy  = 0;
        end else begin
            if (m_active && m_elapsed == m_lat) m_active = 0;
            if (m_active) begin
                m_elapsed++;
            end else if (Enable && !m_en_prev) begin
                m_active  = 1;
                m_elapsed = 0;
                if (N == 0) begin
                    m_lat    = 1;
                    pend_err = 1;
                    pend_r   = P;
                end else begin
                    m_lat    = W + 1;
                    pend_err = 0;
                    pend_r   = P % N;
                end
            end
            m_en_prev = Enable;
            exp_done  = m_active && (m_elapsed == m_lat);
            exp_busy  = m_active && !pend_err && (m_elapsed < W);
            if (exp_done) begin
                m_R   = pend_r;
                m_Err = pend_err;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("cyc_done", Done, exp_done);
        check("cyc_busy", Busy, exp_busy);
        check("cyc_r",    R,    m_R);
        check("cyc_err",  Err,  m_Err);
        if (Done) done_cnt++;
    end

    // Wait (bounded) for Done after a capture edge; lat = edges after capture
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (Done) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] p, input logic [W-1:0] n,
                          input logic [W-1:0] exp_r, input bit exp_err, input int exp_lat);
        int lat;
        @(posedge clk);
        #2 P = p; N = n; Enable = 1'b1;
        @(posedge clk);
        // Operands change right after capture; the result must not follow them
        #2 Enable = 1'b0; P = ~p; N = ~n;
        wait_done(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_r"},   R,   exp_r);
        check({tag, "_err"}, Err, exp_err);
        @(posedge clk);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_r",    R,    0);
        check("rst_done", Done, 0);
        check("rst_busy", Busy, 0);
        check("rst_err",  Err,  0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Basic results and the P<N boundary
        run_op("t1_143_13", 8'd143, 8'd13, 8'd0,  0, 9);
        run_op("t2_225_33", 8'd225, 8'd33, 8'd27, 0, 9);
        run_op("t2_10_33",  8'd10,  8'd33, 8'd10, 0, 9);

        // Zero modulus, then recovery clears Err
        run_op("t3_77_0",   8'd77,  8'd0,  8'd77, 1, 1);
        run_op("t3_77_7",   8'd77,  8'd7,  8'd0,  0, 9);

        // Remaining boundaries: N=1, P=0, P=N, max operands
        run_op("b_n1",      8'd200, 8'd1,   8'd0,   0, 9);
        run_op("b_p0",      8'd0,   8'd45,  8'd0,   0, 9);
        run_op("b_peqn",    8'd99,  8'd99,  8'd0,   0, 9);
        run_op("b_max",     8'd255, 8'd254, 8'd1,   0, 9);

        // Enable held high: exactly one reduction
        @(posedge clk);
        #2 P = 8'd100; N = 8'd7; Enable = 1'b1; done_cnt = 0;
        repeat (30) @(posedge clk);
        #2 Enable = 1'b0;
        repeat (2) @(posedge clk);
        check("hold_pulses", done_cnt, 1);
        check("hold_r",      R,        2);

        // Enable toggled during CALC with new operands: no restart
        @(posedge clk);
        #2 P = 8'd250; N = 8'd11; Enable = 1'b1;
        @(posedge clk);
        #2 Enable = 1'b0; done_cnt = 0;
        repeat (2) @(posedge clk);
        #2 Enable = 1'b1; P = 8'd3; N = 8'd5;
        @(posedge clk);
        #2 Enable = 1'b0;
        wait_done(lat);
        check("tog_lat", lat, 6);
        check("tog_r",   R,   8);
        repeat (3) @(posedge clk);
        check("tog_pulses", done_cnt, 1);

        // Reset in the middle of CALC
        @(posedge clk);
        #2 P = 8'd60; N = 8'd7; Enable = 1'b1;
        @(posedge clk);
        #2 Enable = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_r",    R,    0);
        check("mid_rst_done", Done, 0);
        check("mid_rst_busy", Busy, 0);
        done_cnt = 0;
        repeat (12) @(posedge clk);
        check("mid_rst_nodone", done_cnt, 0);
        #2 rst_n = 1'b1;
        run_op("t5_200_9", 8'd200, 8'd9, 8'd2, 0, 9);

        // Sweep across the product range against plain modulo
        for (int p = 0; p <= 225; p += 15) begin
            for (int n = 1; n <= 257; n += 8) begin
                int nn;
                nn = (n > 255) ? 255 : n;
                run_op("sweep", 8'(p), 8'(nn), 8'(p % nn), 0, 9);
            end
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, miscompares %0d", miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
